// File: rtl/multi_pkg.sv
// Shared definitions for the multi-library token-port blocks: handshake constants,
// the data-width clamp for token-only instances, and a modulo pointer increment.
`ifndef MULTI_DATA_W
`define MULTI_DATA_W(w) (((w) == 0) ? 1 : (w))
`endif

package multi_pkg;

    // Token-port triple: a value, its VALID flag and its CONSUMED strobe.
    localparam logic TOK_TAKE = 1'b1;
    localparam logic TOK_HOLD = 1'b0;

    // Increment a ring pointer, wrapping at depth (depth need not be a power of two here).
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return ((ptr + 32'd1) == depth) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/multi_fifo_ctrl.sv
// FIFO bookkeeping: head/tail pointers, occupancy and token accept decisions.
// MULTI_FIFO_PIPE_EN lets a full FIFO accept an enqueue when a dequeue happens the same cycle.
module multi_fifo_ctrl
    import multi_pkg::*;
#(
    parameter int unsigned depth = 4,
    parameter int unsigned logd  = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            enc_in,
    input  logic            en_enq,
    input  logic            en_deq_valid,
    input  logic            en_deq,
    output logic            enc_ok,
    output logic            dec_ok,
    output logic            do_enq,
    output logic            do_deq,
    output logic [logd-1:0] head_next,
    output logic [logd-1:0] tail,
    output logic [logd:0]   cnt
);

    localparam logic [logd:0] CNT_FULL = (logd + 1)'(depth);

    logic [logd-1:0] head_reg, tail_reg, tail_next;
    logic [logd:0]   cnt_reg, cnt_next;
    logic            full, empty;

    assign full  = (cnt_reg == CNT_FULL);
    assign empty = (cnt_reg == '0);

    assign dec_ok = en_deq_valid && (!en_deq || !empty);
    assign do_deq = dec_ok && en_deq;

`ifdef MULTI_FIFO_PIPE_EN
    // The slot freed by a same-cycle dequeue is reused immediately.
    assign enc_ok = enc_in && (!en_enq || !full || do_deq);
`else
    assign enc_ok = enc_in && (!en_enq || !full);
`endif
    assign do_enq = enc_ok && en_enq;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        cnt_next  = cnt_reg;
        if (do_deq) begin
            head_next = logd'(ptr_inc(32'(head_reg), depth));
        end
        if (do_enq) begin
            tail_next = logd'(ptr_inc(32'(tail_reg), depth));
        end
        case ({do_enq, do_deq})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign tail = tail_reg;
    assign cnt  = cnt_reg;

endmodule

// File: rtl/multi_fifo_buf.sv
// Bounded FIFO with VALID/CONSUMED token ports; head entry is presented as a readable port.
// Define MULTI_FIFO_PIPE_EN for pipeline behaviour (enqueue into a full FIFO alongside a dequeue).
module multi_fifo_buf
    import multi_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4,
    parameter int unsigned logd  = 2
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [`MULTI_DATA_W(width)-1:0] IN_ENQ,
    input  logic                            IN_ENQ_VALID,
    output logic                            IN_ENQ_CONSUMED,
    input  logic                            IN_EN_ENQ,
    input  logic                            IN_EN_ENQ_VALID,
    output logic                            IN_EN_ENQ_CONSUMED,
    input  logic                            IN_EN_DEQ,
    input  logic                            IN_EN_DEQ_VALID,
    output logic                            IN_EN_DEQ_CONSUMED,
    output logic [`MULTI_DATA_W(width)-1:0] OUT_FIRST,
    output logic                            OUT_FIRST_VALID,
    input  logic                            OUT_FIRST_CONSUMED,
    output logic [logd:0]                   OUT_COUNT
);

    localparam int unsigned DW = `MULTI_DATA_W(width);

    logic            enq_valid_eff;
    logic            enc_in, enc_ok, dec_ok, do_enq, do_deq;
    logic [logd-1:0] head_next, tail;
    logic [logd:0]   cnt;
    logic            unused_first_consumed;

    assign unused_first_consumed = OUT_FIRST_CONSUMED;

    assign enc_in = enq_valid_eff && IN_EN_ENQ_VALID;

    multi_fifo_ctrl #(
        .depth (depth),
        .logd  (logd)
    ) u_ctrl (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .enc_in       (enc_in),
        .en_enq       (IN_EN_ENQ),
        .en_deq_valid (IN_EN_DEQ_VALID),
        .en_deq       (IN_EN_DEQ),
        .enc_ok       (enc_ok),
        .dec_ok       (dec_ok),
        .do_enq       (do_enq),
        .do_deq       (do_deq),
        .head_next    (head_next),
        .tail         (tail),
        .cnt          (cnt)
    );

    generate
        if (width == 0) begin : g_token
            logic unused_token_side;
            assign enq_valid_eff     = TOK_TAKE;
            assign unused_token_side = ^{IN_ENQ, IN_ENQ_VALID, head_next, tail, do_deq};
            assign OUT_FIRST         = '0;
        end else begin : g_data
            logic [DW-1:0] mem [depth];
            logic [DW-1:0] first_reg;

            assign enq_valid_eff = IN_ENQ_VALID;

            // Registered read of the next head; a write landing on that slot is forwarded.
            always_ff @(posedge CLK) begin
                if (do_enq) begin
                    mem[tail] <= IN_ENQ;
                end
                first_reg <= (do_enq && (tail == head_next)) ? IN_ENQ : mem[head_next];
            end

            assign OUT_FIRST = first_reg;
        end
    endgenerate

    assign IN_ENQ_CONSUMED    = enc_ok;
    assign IN_EN_ENQ_CONSUMED = enc_ok;
    assign IN_EN_DEQ_CONSUMED = dec_ok;
    assign OUT_FIRST_VALID    = (cnt != '0);
    assign OUT_COUNT          = cnt;

endmodule

// File: tb/tb_multi_fifo_buf.sv
// Directed self-checking bench for multi_fifo_buf (width=8, depth=4).
module tb_multi_fifo_buf;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] IN_ENQ;
    logic       IN_ENQ_VALID, IN_ENQ_CONSUMED;
    logic       IN_EN_ENQ, IN_EN_ENQ_VALID, IN_EN_ENQ_CONSUMED;
    logic       IN_EN_DEQ, IN_EN_DEQ_VALID, IN_EN_DEQ_CONSUMED;
    logic [7:0] OUT_FIRST;
    logic       OUT_FIRST_VALID, OUT_FIRST_CONSUMED;
    logic [2:0] OUT_COUNT;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    multi_fifo_buf #(.width(8), .depth(4), .logd(2)) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .IN_ENQ             (IN_ENQ),
        .IN_ENQ_VALID       (IN_ENQ_VALID),
        .IN_ENQ_CONSUMED    (IN_ENQ_CONSUMED),
        .IN_EN_ENQ          (IN_EN_ENQ),
        .IN_EN_ENQ_VALID    (IN_EN_ENQ_VALID),
        .IN_EN_ENQ_CONSUMED (IN_EN_ENQ_CONSUMED),
        .IN_EN_DEQ          (IN_EN_DEQ),
        .IN_EN_DEQ_VALID    (IN_EN_DEQ_VALID),
        .IN_EN_DEQ_CONSUMED (IN_EN_DEQ_CONSUMED),
        .OUT_FIRST          (OUT_FIRST),
        .OUT_FIRST_VALID    (OUT_FIRST_VALID),
        .OUT_FIRST_CONSUMED (OUT_FIRST_CONSUMED),
        .OUT_COUNT          (OUT_COUNT)
    );

    task automatic idle();
        IN_ENQ             = 8'h00;
        IN_ENQ_VALID       = 1'b0;
        IN_EN_ENQ          = 1'b0;
        IN_EN_ENQ_VALID    = 1'b0;
        IN_EN_DEQ          = 1'b0;
        IN_EN_DEQ_VALID    = 1'b0;
        OUT_FIRST_CONSUMED = 1'b0;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_enq(input logic [7:0] d);
        IN_ENQ          = d;
        IN_ENQ_VALID    = 1'b1;
        IN_EN_ENQ       = 1'b1;
        IN_EN_ENQ_VALID = 1'b1;
    endtask

    task automatic drive_deq();
        IN_EN_DEQ          = 1'b1;
        IN_EN_DEQ_VALID    = 1'b1;
        OUT_FIRST_CONSUMED = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle();
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        #2;
        $display("reset released");
        checks++; if (OUT_FIRST_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", OUT_FIRST_VALID); end
        checks++; if (OUT_COUNT !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", OUT_COUNT); end
        checks++; if (IN_ENQ_CONSUMED !== 1'b0) begin failures++; $display("FAIL reset_enq_cons: got %b expected 0", IN_ENQ_CONSUMED); end
        checks++; if (IN_EN_ENQ_CONSUMED !== 1'b0) begin failures++; $display("FAIL reset_en_enq_cons: got %b expected 0", IN_EN_ENQ_CONSUMED); end
        checks++; if (IN_EN_DEQ_CONSUMED !== 1'b0) begin failures++; $display("FAIL reset_deq_cons: got %b expected 0", IN_EN_DEQ_CONSUMED); end
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive_enq(vals[i]);
            #2;
            $display("enq data=%h", vals[i]);
            checks++; if (IN_ENQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL fill_enq_cons[%0d]: got %b expected 1", i, IN_ENQ_CONSUMED); end
            checks++; if (IN_EN_ENQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL fill_en_cons[%0d]: got %b expected 1", i, IN_EN_ENQ_CONSUMED); end
            tick();
            idle();
            checks++; if (OUT_COUNT !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, OUT_COUNT, i + 1); end
        end
        checks++; if (OUT_FIRST !== 8'h11) begin failures++; $display("FAIL fill_first: got %h expected 11", OUT_FIRST); end
        drive_enq(8'h55);
        #2;
        $display("enq data=55 while full");
        checks++; if (IN_ENQ_CONSUMED !== 1'b0) begin failures++; $display("FAIL full_enq_cons: got %b expected 0", IN_ENQ_CONSUMED); end
        checks++; if (IN_EN_ENQ_CONSUMED !== 1'b0) begin failures++; $display("FAIL full_en_cons: got %b expected 0", IN_EN_ENQ_CONSUMED); end
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'd4) begin failures++; $display("FAIL full_count: got %0d expected 4", OUT_COUNT); end
        checks++; if (OUT_FIRST !== 8'h11) begin failures++; $display("FAIL full_first: got %h expected 11", OUT_FIRST); end
    endtask

    task automatic test_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            checks++; if (OUT_FIRST !== vals[i]) begin failures++; $display("FAIL drain_first[%0d]: got %h expected %h", i, OUT_FIRST, vals[i]); end
            checks++; if (OUT_FIRST_VALID !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, OUT_FIRST_VALID); end
            drive_deq();
            #2;
            $display("deq data=%h", OUT_FIRST);
            checks++; if (IN_EN_DEQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL drain_cons[%0d]: got %b expected 1", i, IN_EN_DEQ_CONSUMED); end
            tick();
            idle();
        end
        checks++; if (OUT_FIRST_VALID !== 1'b0) begin failures++; $display("FAIL drained_valid: got %b expected 0", OUT_FIRST_VALID); end
        checks++; if (OUT_COUNT !== 3'd0) begin failures++; $display("FAIL drained_count: got %0d expected 0", OUT_COUNT); end
        drive_deq();
        #2;
        $display("deq on empty");
        checks++; if (IN_EN_DEQ_CONSUMED !== 1'b0) begin failures++; $display("FAIL empty_deq_cons: got %b expected 0", IN_EN_DEQ_CONSUMED); end
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'd0) begin failures++; $display("FAIL empty_deq_count: got %0d expected 0", OUT_COUNT); end
        IN_EN_DEQ_VALID = 1'b1;
        #2;
        $display("deq enable=0 on empty");
        checks++; if (IN_EN_DEQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL deq_en0_cons: got %b expected 1", IN_EN_DEQ_CONSUMED); end
        tick();
        idle();
    endtask

    task automatic test_empty_enq_deq();
        drive_enq(8'h5A);
        drive_deq();
        #2;
        $display("enq data=5a + deq on empty");
        checks++; if (IN_ENQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL empty_both_enq_cons: got %b expected 1", IN_ENQ_CONSUMED); end
        checks++; if (IN_EN_DEQ_CONSUMED !== 1'b0) begin failures++; $display("FAIL empty_both_deq_cons: got %b expected 0", IN_EN_DEQ_CONSUMED); end
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'd1) begin failures++; $display("FAIL empty_both_count: got %0d expected 1", OUT_COUNT); end
        checks++; if (OUT_FIRST !== 8'h5A) begin failures++; $display("FAIL empty_both_first: got %h expected 5a", OUT_FIRST); end
    endtask

    task automatic test_back_to_back();
        drive_enq(8'h6B);
        drive_deq();
        #2;
        $display("enq data=6b + deq at count 1");
        checks++; if (IN_ENQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL b2b_enq_cons: got %b expected 1", IN_ENQ_CONSUMED); end
        checks++; if (IN_EN_DEQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL b2b_deq_cons: got %b expected 1", IN_EN_DEQ_CONSUMED); end
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'd1) begin failures++; $display("FAIL b2b_count: got %0d expected 1", OUT_COUNT); end
        checks++; if (OUT_FIRST !== 8'h6B) begin failures++; $display("FAIL b2b_first: got %h expected 6b", OUT_FIRST); end
        drive_deq();
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'd0) begin failures++; $display("FAIL b2b_drain_count: got %0d expected 0", OUT_COUNT); end
    endtask

    task automatic test_full_enq_deq();
        logic [7:0] exp_q [$];
        logic       exp_enq_cons;
        int         exp_cnt;
`ifdef MULTI_FIFO_PIPE_EN
        exp_enq_cons = 1'b1;
        exp_cnt      = 4;
        exp_q        = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
`else
        exp_enq_cons = 1'b0;
        exp_cnt      = 3;
        exp_q        = '{8'hA1, 8'hA2, 8'hA3};
`endif
        for (int i = 0; i < 4; i++) begin
            drive_enq(8'hA0 + 8'(i));
            tick();
            idle();
        end
        checks++; if (OUT_COUNT !== 3'd4) begin failures++; $display("FAIL fed_prefill_count: got %0d expected 4", OUT_COUNT); end
        drive_enq(8'h55);
        drive_deq();
        #2;
        $display("enq data=55 + deq while full");
        checks++; if (IN_EN_DEQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL fed_deq_cons: got %b expected 1", IN_EN_DEQ_CONSUMED); end
        checks++; if (IN_ENQ_CONSUMED !== exp_enq_cons) begin failures++; $display("FAIL fed_enq_cons: got %b expected %b", IN_ENQ_CONSUMED, exp_enq_cons); end
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'(exp_cnt)) begin failures++; $display("FAIL fed_count: got %0d expected %0d", OUT_COUNT, exp_cnt); end
        foreach (exp_q[i]) begin
            checks++; if (OUT_FIRST !== exp_q[i]) begin failures++; $display("FAIL fed_drain[%0d]: got %h expected %h", i, OUT_FIRST, exp_q[i]); end
            drive_deq();
            tick();
            idle();
        end
        checks++; if (OUT_COUNT !== 3'd0) begin failures++; $display("FAIL fed_end_count: got %0d expected 0", OUT_COUNT); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            drive_enq(8'(i));
            tick();
            idle();
            $display("wrap enq data=%h", 8'(i));
            checks++; if (OUT_FIRST !== 8'(i)) begin failures++; $display("FAIL wrap_first[%0d]: got %h expected %h", i, OUT_FIRST, 8'(i)); end
            drive_deq();
            tick();
            idle();
            checks++; if (OUT_COUNT !== 3'd0) begin failures++; $display("FAIL wrap_count[%0d]: got %0d expected 0", i, OUT_COUNT); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_enq(8'hC1 + 8'(i));
            tick();
            idle();
        end
        checks++; if (OUT_COUNT !== 3'd3) begin failures++; $display("FAIL mid_pre_count: got %0d expected 3", OUT_COUNT); end
        RST_N = 1'b0;
        tick();
        $display("reset asserted at count 3");
        checks++; if (OUT_COUNT !== 3'd0) begin failures++; $display("FAIL mid_rst_count: got %0d expected 0", OUT_COUNT); end
        checks++; if (OUT_FIRST_VALID !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", OUT_FIRST_VALID); end
        RST_N = 1'b1;
        drive_enq(8'h77);
        tick();
        idle();
        IN_ENQ          = 8'h99;
        IN_ENQ_VALID    = 1'b1;
        IN_EN_ENQ_VALID = 1'b1;
        #2;
        $display("enq enable=0 at count 1");
        checks++; if (IN_ENQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL en0_enq_cons: got %b expected 1", IN_ENQ_CONSUMED); end
        checks++; if (IN_EN_ENQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL en0_en_cons: got %b expected 1", IN_EN_ENQ_CONSUMED); end
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'd1) begin failures++; $display("FAIL en0_count: got %0d expected 1", OUT_COUNT); end
        checks++; if (OUT_FIRST !== 8'h77) begin failures++; $display("FAIL en0_first: got %h expected 77", OUT_FIRST); end
        for (int i = 0; i < 3; i++) begin
            drive_enq(8'h78 + 8'(i));
            tick();
            idle();
        end
        IN_ENQ_VALID    = 1'b1;
        IN_EN_ENQ_VALID = 1'b1;
        #2;
        $display("enq enable=0 while full");
        checks++; if (IN_ENQ_CONSUMED !== 1'b1) begin failures++; $display("FAIL en0_full_cons: got %b expected 1", IN_ENQ_CONSUMED); end
        tick();
        idle();
        checks++; if (OUT_COUNT !== 3'd4) begin failures++; $display("FAIL en0_full_count: got %0d expected 4", OUT_COUNT); end
    endtask

    initial begin
        RST_N = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_empty_enq_deq();
        test_back_to_back();
        test_full_enq_deq();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
